// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the register-file write-back arbiter.
// Covers the register index type, the requester encoding and the default parameter values.
package regfile_pkg;

  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 32;
  localparam int ZERO_REG  = 31;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic {
    ALU = 1'b0,
    LD  = 1'b1
  } req_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-destination scoreboard: an issue sets a bit, a write-back clears it,
// and the block answers the operand hazard queries and reports a registered population count.
module regfile_scoreboard #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       issue_i,
  input  logic [4:0] issue_rc_i,
  input  logic       clr_i,
  input  logic [4:0] clr_rc_i,
  input  logic [4:0] qa_i,
  input  logic [4:0] qb_i,
  output logic       busy_a_o,
  output logic       busy_b_o,
  output logic [5:0] pending_cnt_o
);
  import regfile_pkg::*;

  localparam reg_idx_t ZERO_IDX = reg_idx_t'(ZERO_REG);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_nxt;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [5:0]          cnt_q;

  function automatic logic [5:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++) c = c + 6'(v[i]);
    return c;
  endfunction

  // Set is applied after clear so a same-cycle issue keeps the bit reserved.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_i && issue_rc_i != ZERO_IDX) set_mask[issue_rc_i] = 1'b1;
    if (clr_i) clr_mask[clr_rc_i] = 1'b1;
    pending_nxt           = (pending_q & ~clr_mask) | set_mask;
    pending_nxt[ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_nxt;
      cnt_q     <= popcount(pending_q);
    end
  end

  assign busy_a_o      = pending_q[qa_i];
  assign busy_b_o      = pending_q[qb_i];
  assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter between ALU and load write-back requests feeding a single
// register-file write port, with a destination scoreboard for hazard queries.
module regfile_wb_arbiter #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              alu_valid_i,
  input  logic [4:0]        alu_rc_i,
  input  logic [DATA_W-1:0] alu_wd_i,
  output logic              alu_ready_o,
  input  logic              ld_valid_i,
  input  logic [4:0]        ld_rc_i,
  input  logic [DATA_W-1:0] ld_wd_i,
  output logic              ld_ready_o,
  input  logic              issue_i,
  input  logic [4:0]        issue_rc_i,
  input  logic [4:0]        qa_i,
  input  logic [4:0]        qb_i,
  output logic              busy_a_o,
  output logic              busy_b_o,
  output logic              werf_o,
  output logic [4:0]        rc_o,
  output logic [DATA_W-1:0] wd_o,
  output logic [5:0]        pending_cnt_o
);
  import regfile_pkg::*;

  localparam reg_idx_t ZERO_IDX = reg_idx_t'(ZERO_REG);

  req_e              rr_ptr;
  logic              contest_p0;
  logic              xfer_p0;
  reg_idx_t          rc_p0;
  logic [DATA_W-1:0] wd_p0;
  logic              werf_p1;
  reg_idx_t          rc_p1;
  logic [DATA_W-1:0] wd_p1;

  // Stage p0: combinational grant and write-data select
  always_comb begin
    contest_p0  = alu_valid_i && ld_valid_i;
    alu_ready_o = alu_valid_i && (!ld_valid_i || rr_ptr == ALU);
    ld_ready_o  = ld_valid_i && (!alu_valid_i || rr_ptr == LD);
    xfer_p0     = alu_ready_o || ld_ready_o;
    rc_p0       = ld_ready_o ? ld_rc_i : alu_rc_i;
    wd_p0       = ld_ready_o ? ld_wd_i : alu_wd_i;
  end

  // Stage p1: registered write port; zero-register writes are accepted but never strobed
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_ptr  <= LD;
      werf_p1 <= 1'b0;
      rc_p1   <= '0;
      wd_p1   <= '0;
    end else begin
      if (contest_p0) rr_ptr <= (rr_ptr == ALU) ? LD : ALU;
      werf_p1 <= xfer_p0 && (rc_p0 != ZERO_IDX);
      if (xfer_p0) begin
        rc_p1 <= rc_p0;
        wd_p1 <= wd_p0;
      end
    end
  end

  assign werf_o = werf_p1;
  assign rc_o   = rc_p1;
  assign wd_o   = wd_p1;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .issue_i       (issue_i),
    .issue_rc_i    (issue_rc_i),
    .clr_i         (werf_p1),
    .clr_rc_i      (rc_p1),
    .qa_i          (qa_i),
    .qb_i          (qb_i),
    .busy_a_o      (busy_a_o),
    .busy_b_o      (busy_b_o),
    .pending_cnt_o (pending_cnt_o)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized
// phase, all compared every cycle against a behavioural model of the arbiter and scoreboard.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, ld_valid = 1'b0, issue = 1'b0;
  logic [4:0]  alu_rc = '0, ld_rc = '0, issue_rc = '0, qa = '0, qb = '0;
  logic [31:0] alu_wd = '0, ld_wd = '0;
  logic        alu_ready, ld_ready, busy_a, busy_b, werf;
  logic [4:0]  rc;
  logic [31:0] wd;
  logic [5:0]  pending_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  regfile_wb_arbiter dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .alu_valid_i   (alu_valid),
    .alu_rc_i      (alu_rc),
    .alu_wd_i      (alu_wd),
    .alu_ready_o   (alu_ready),
    .ld_valid_i    (ld_valid),
    .ld_rc_i       (ld_rc),
    .ld_wd_i       (ld_wd),
    .ld_ready_o    (ld_ready),
    .issue_i       (issue),
    .issue_rc_i    (issue_rc),
    .qa_i          (qa),
    .qb_i          (qb),
    .busy_a_o      (busy_a),
    .busy_b_o      (busy_b),
    .werf_o        (werf),
    .rc_o          (rc),
    .wd_o          (wd),
    .pending_cnt_o (pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: reservation set, pending write-back, and whose turn a contest is.
  bit          pend[32];
  int          cnt_m = 0;
  bit          wb_v = 1'b0;
  logic [4:0]  wb_rc = '0;
  logic [31:0] wb_wd = '0;
  bit          ld_turn = 1'b1;

  function automatic bit m_alu_rdy();
    return alu_valid && (!ld_valid || !ld_turn);
  endfunction

  function automatic bit m_ld_rdy();
    return ld_valid && (!alu_valid || ld_turn);
  endfunction

  function automatic int m_count();
    int c = 0;
    foreach (pend[i]) c += int'(pend[i]);
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (pend[i]) pend[i] <= 1'b0;
      cnt_m   <= 0;
      wb_v    <= 1'b0;
      wb_rc   <= '0;
      wb_wd   <= '0;
      ld_turn <= 1'b1;
    end else begin
      cnt_m <= m_count();
      if (wb_v && wb_rc != 5'd31) pend[wb_rc] <= 1'b0;
      if (issue && issue_rc != 5'd31) pend[issue_rc] <= 1'b1;
      wb_v <= m_alu_rdy() || m_ld_rdy();
      if (m_ld_rdy()) begin
        wb_rc <= ld_rc;
        wb_wd <= ld_wd;
      end else if (m_alu_rdy()) begin
        wb_rc <= alu_rc;
        wb_wd <= alu_wd;
      end
      if (alu_valid && ld_valid) ld_turn <= !ld_turn;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("alu_ready", alu_ready, m_alu_rdy());
      cmp("ld_ready", ld_ready, m_ld_rdy());
      cmp("werf", werf, wb_v && wb_rc != 5'd31);
      if (wb_v && wb_rc != 5'd31) begin
        cmp("rc", rc, wb_rc);
        cmp("wd", wd, wb_wd);
      end
      if (!rst_n) begin
        cmp("rst_rc", rc, 0);
        cmp("rst_wd", wd, 0);
      end
      cmp("busy_a", busy_a, pend[qa]);
      cmp("busy_b", busy_b, pend[qb]);
      cmp("pending_cnt", pending_cnt, cnt_m);
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic drive(input bit av, input logic [4:0] ar, input logic [31:0] aw,
                       input bit lv, input logic [4:0] lr, input logic [31:0] lw,
                       input bit iv, input logic [4:0] ir, input logic [4:0] a, input logic [4:0] b);
    alu_valid = av; alu_rc = ar; alu_wd = aw;
    ld_valid = lv; ld_rc = lr; ld_wd = lw;
    issue = iv; issue_rc = ir; qa = a; qb = b;
  endtask

  function automatic logic [4:0] rnd_rc();
    int r = $urandom_range(0, 9);
    return (r >= 8) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    step();
    chk_on = 1'b1;
    step();
    #1;
    cmp("rst_werf", werf, 0);
    cmp("rst_cnt", pending_cnt, 0);
    cmp("rst_rc_lit", rc, 0);
    rst_n = 1'b1;

    // Single ALU write
    step(); drive(1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    #1 cmp("s1_alu_ready", alu_ready, 1);
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 cmp("s1_werf", werf, 1);
    cmp("s1_rc", rc, 3);
    cmp("s1_wd", wd, 32'hDEADBEEF);
    step();
    #1 cmp("s1_werf_after", werf, 0);

    // Contention: LD first after reset, then alternate
    for (int k = 0; k < 4; k++) begin
      step(); drive(1, 5'd1, 32'h1111, 1, 5'd2, 32'h2222, 0, 0, 0, 0);
      #1 cmp("s2_ld_grant", ld_ready, (k % 2 == 0));
      cmp("s2_alu_grant", alu_ready, (k % 2 == 1));
      if (k > 0) begin
        cmp("s2_werf", werf, 1);
        cmp("s2_rc", rc, ((k - 1) % 2 == 0) ? 2 : 1);
      end
    end
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 cmp("s2_werf_last", werf, 1);
    cmp("s2_rc_last", rc, 1);
    step();
    #1 cmp("s2_werf_end", werf, 0);

    // Zero register
    step(); drive(0, 0, 0, 1, 5'd31, 32'hABCD, 1, 5'd31, 5'd31, 5'd31);
    #1 cmp("s3_ld_ready", ld_ready, 1);
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd31, 5'd31);
    #1 cmp("s3_busy", busy_a, 0);
    cmp("s3_werf", werf, 0);
    step();
    #1 cmp("s3_cnt", pending_cnt, 0);
    cmp("s3_werf2", werf, 0);

    // Scoreboard set then clear
    step(); drive(0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 0);
    #1 cmp("s4_busy_nobypass", busy_a, 0);
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 0);
    #1 cmp("s4_busy_set", busy_a, 1);
    cmp("s4_cnt0", pending_cnt, 0);
    step(); drive(1, 5'd5, 32'h55, 0, 0, 0, 0, 0, 5'd5, 0);
    #1 cmp("s4_cnt1", pending_cnt, 1);
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 0);
    #1 cmp("s4_werf", werf, 1);
    cmp("s4_busy_wb", busy_a, 1);
    step();
    #1 cmp("s4_busy_clr", busy_a, 0);
    step();
    #1 cmp("s4_cnt_back", pending_cnt, 0);

    // Simultaneous set and clear
    step(); drive(0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 5'd7);
    step(); drive(1, 5'd7, 32'h77, 0, 0, 0, 0, 0, 0, 5'd7);
    step(); drive(0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 5'd7);
    #1 cmp("s5_werf", werf, 1);
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7);
    #1 cmp("s5_busy_kept", busy_b, 1);
    cmp("s5_werf_end", werf, 0);

    // Reset mid-operation: clear reg 7 first so exactly three are pending
    step(); drive(1, 5'd7, 0, 0, 0, 0, 1, 5'd10, 5'd10, 0);
    step(); drive(0, 0, 0, 0, 0, 0, 1, 5'd11, 5'd10, 0);
    step(); drive(0, 0, 0, 0, 0, 0, 1, 5'd12, 5'd10, 0);
    step(); drive(1, 5'd10, 32'hCAFE, 0, 0, 0, 0, 0, 5'd10, 0);
    @(posedge clk);
    #1 cmp("s6_cnt_pre", pending_cnt, 3);
    cmp("s6_werf_pre", werf, 1);
    drive(1, 5'd4, 32'h4, 0, 0, 0, 0, 0, 5'd10, 0);
    #1 rst_n = 1'b0;
    #1 cmp("s6_werf_rst", werf, 0);
    cmp("s6_cnt_rst", pending_cnt, 0);
    cmp("s6_busy_rst", busy_a, 0);
    cmp("s6_ready_in_rst", alu_ready, 1);
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd10, 0);
    rst_n = 1'b1;
    step();
    #1 cmp("s6_werf_after", werf, 0);
    step();
    #1 cmp("s6_werf_after2", werf, 0);
    cmp("s6_cnt_after", pending_cnt, 0);

    // Randomized traffic with one asynchronous reset pulse
    for (int i = 0; i < 600; i++) begin
      step();
      drive($urandom_range(0, 1), rnd_rc(), $urandom, $urandom_range(0, 1), rnd_rc(), $urandom,
            ($urandom_range(0, 2) == 0), rnd_rc(), rnd_rc(), rnd_rc());
      if (i == 300) begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
    end
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    @(negedge clk);
    #1 $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
